serial_fs: RTL and testbench

Bit-serial full subtractor computing `diff = a - b - bin` over `WIDTH`-bit operands. It processes one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the subtracting counterpart of the team's combinational full adder (`a`, `b`, carry-in → sum, carry) and trades latency for a one-bit datapath. Operands load on a `start` pulse, and the result is presented with a one-cycle `done` pulse.

---
 rtl/serial_fs.sv | 112 +++++++++++
 tb/tb_serial_fs.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_fs.sv
// Bit-serial full subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands load on start; result and borrow-out are held until the next completion.
module serial_fs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              br_q, br_d, bout_q, bout_d, busy_q, busy_d, done_q, done_d;

    logic              ai, bi, dbit, br_next;
    logic [WIDTH-1:0]  res_next;

    // One full-subtractor cell shared across all bit positions.
    assign ai       = a_q[0];
    assign bi       = b_q[0];
    assign dbit     = ai ^ bi ^ br_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign res_next = (res_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                res_d  = res_next;
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                busy_d = 1'b1;
                if (cnt_q == LastCnt) begin
                    diff_d  = res_next;
                    bout_d  = br_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_fs.sv
// Directed bench for serial_fs: WIDTH=8 vector table plus corner sequences,
// and an exhaustive WIDTH=1 instance.
module tb_serial_fs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;
    logic       start1 = 1'b0, bin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_fs #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_fs #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accepts one WIDTH=8 request; returns edges from acceptance (inclusive) to done.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int edges, output int busy_cycles);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        edges = 0;
        busy_cycles = 0;
        tick();
        edges++;
        start8 = 1'b0;
        while (!done8 && edges < 30) begin
            if (busy8) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    task automatic wait_done8(output int edges);
        edges = 0;
        while (!done8 && edges < 30) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int edges, bc, e2;
        int exp_d, exp_b;
        logic ea, eb, ec;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h0A, 8'h01, 1'b0, 8'h09, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[6] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        vecs[7] = '{8'h64, 8'h32, 1'b1, 8'h31, 1'b0};

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst busy8", {31'b0, busy8}, 0);
        check("rst done8", {31'b0, done8}, 0);
        check("rst diff8", {24'b0, diff8}, 0);
        check("rst bout8", {31'b0, bout8}, 0);
        check("rst busy1", {31'b0, busy1}, 0);
        check("rst diff1", {31'b0, diff1}, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven WIDTH=8 vectors
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].bin, edges, bc);
            check($sformatf("vec%0d edges", i), edges, 9);
            check($sformatf("vec%0d busy cycles", i), bc, 8);
            check($sformatf("vec%0d diff", i), {24'b0, diff8}, {24'b0, vecs[i].diff});
            check($sformatf("vec%0d bout", i), {31'b0, bout8}, {31'b0, vecs[i].bout});
            check($sformatf("vec%0d busy at done", i), {31'b0, busy8}, 0);
            tick();
            check($sformatf("vec%0d done pulse width", i), {31'b0, done8}, 0);
        end

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            ea = v[2]; eb = v[1]; ec = v[0];
            exp_d = (int'(ea) - int'(eb) - int'(ec)) & 1;
            exp_b = (int'(ea) < int'(eb) + int'(ec)) ? 1 : 0;
            a1 = ea; b1 = eb; bin1 = ec; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            edges = 1;
            while (!done1 && edges < 10) begin
                tick();
                edges++;
            end
            check($sformatf("w1 %0d edges", i), edges, 2);
            check($sformatf("w1 %0d diff", i), {31'b0, diff1}, exp_d);
            check($sformatf("w1 %0d bout", i), {31'b0, bout1}, exp_b);
            tick();
        end

        // start during RUN ignored, then back-to-back start in DONE
        a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8(e2);
        check("ignore done seen", {31'b0, done8}, 1);
        check("ignore diff", {24'b0, diff8}, 8'h7F);
        check("ignore bout", {31'b0, bout8}, 0);
        a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("b2b busy", {31'b0, busy8}, 1);
        check("b2b done low", {31'b0, done8}, 0);
        wait_done8(e2);
        check("b2b edges", e2 + 1, 9);
        check("b2b diff", {24'b0, diff8}, 8'hF0);
        check("b2b bout", {31'b0, bout8}, 1);
        tick();

        // Reset mid-RUN aborts
        run8(8'h05, 8'h03, 1'b0, edges, bc);
        check("pre-abort diff", {24'b0, diff8}, 8'h02);
        tick();
        a8 = 8'h0A; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", {31'b0, busy8}, 0);
        check("abort done", {31'b0, done8}, 0);
        check("abort diff", {24'b0, diff8}, 0);
        check("abort bout", {31'b0, bout8}, 0);
        bc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8) bc++;
        end
        check("abort no done", bc, 0);
        run8(8'h0A, 8'h01, 1'b0, edges, bc);
        check("post-abort diff", {24'b0, diff8}, 8'h09);
        check("post-abort bout", {31'b0, bout8}, 0);
        tick();

        // Output hold with idle start and toggling operands
        run8(8'h05, 8'h03, 1'b0, edges, bc);
        check("hold setup diff", {24'b0, diff8}, 8'h02);
        tick();
        for (int i = 0; i < 20; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            bin8 = 1'($urandom);
            tick();
            check("hold diff", {24'b0, diff8}, 8'h02);
            check("hold bout", {31'b0, bout8}, 0);
            check("hold done", {31'b0, done8}, 0);
            check("hold busy", {31'b0, busy8}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
